// File: rtl/uart_cfg_pkg.sv
// Shared definitions for the UART configuration bank.
// Holds the per-channel register offsets, STATUS bit positions, CTRL field
// positions and the commit FSM state encoding used by uart_cfg_channel and
// uart_cfg_bank.
package uart_cfg_pkg;

  // Register offsets inside a channel's 8-entry window
  localparam logic [2:0] OFF_CTRL    = 3'd0;
  localparam logic [2:0] OFF_BAUD    = 3'd1;
  localparam logic [2:0] OFF_STATUS  = 3'd2;
  localparam logic [2:0] OFF_IRQ_EN  = 3'd3;
  localparam logic [2:0] OFF_SCRATCH = 3'd4;

  // STATUS bit positions
  localparam int STAT_BUSY    = 0;
  localparam int STAT_ERROR   = 1;
  localparam int STAT_TIMEOUT = 2;
  localparam int STAT_PENDING = 3;
  localparam int STATUS_W     = 4;

  // CTRL field positions
  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_W   = 3;
  localparam int CTRL_W        = 4;

  localparam int IRQ_EN_W = 3;
  localparam int RATE_W   = 16;

  // Commit FSM: PEND means a new BAUD value waits in the shadow register
  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } commit_state_e;

endpackage

// File: rtl/uart_cfg_channel.sv
// One UART channel's register set and BAUD commit FSM.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   we_*                  one-cycle write strobes, already address-decoded
//   wdata                 write data
//   error, update_ok      hardware status inputs for this channel
//   ctrl, baud, irq_en,
//   scratch               register contents (baud is the active value)
//   err_flag, tmo_flag    sticky STATUS bits
//   commit_req            high while a BAUD update waits for update_ok
//   irq                   registered interrupt
//   state                 commit FSM state (debug visibility)
module uart_cfg_channel
  import uart_cfg_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int BAUD_RST   = 9600,
  parameter int COMMIT_TMO = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_ctrl,
  input  logic                  we_baud,
  input  logic                  we_status,
  input  logic                  we_irq_en,
  input  logic                  we_scratch,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  error,
  input  logic                  update_ok,
  output logic [CTRL_W-1:0]     ctrl,
  output logic [RATE_W-1:0]     baud,
  output logic                  err_flag,
  output logic                  tmo_flag,
  output logic [IRQ_EN_W-1:0]   irq_en,
  output logic [DATA_WIDTH-1:0] scratch,
  output logic                  commit_req,
  output logic                  irq,
  output commit_state_e         state
);

  localparam int CNT_W = (COMMIT_TMO < 1) ? 1 : $clog2(COMMIT_TMO + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(COMMIT_TMO);

  commit_state_e     state_d;
  logic [RATE_W-1:0] shadow;
  logic [CNT_W-1:0]  cnt;
  logic              commit_evt;
  logic              timeout_evt;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // A BAUD write always (re)starts the commit, even over a coincident
  // update_ok; update_ok is checked before the timeout so an acknowledge
  // on the final counted cycle still commits.
  always_comb begin
    state_d     = state;
    commit_evt  = 1'b0;
    timeout_evt = 1'b0;
    if (we_baud) begin
      state_d = PEND;
    end else if (state == PEND) begin
      if (update_ok) begin
        state_d    = IDLE;
        commit_evt = 1'b1;
      end else if (cnt == CNT_MAX) begin
        state_d     = IDLE;
        timeout_evt = 1'b1;
      end
    end
  end

  assign commit_req = (state == PEND);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl     <= '0;
      irq_en   <= '0;
      scratch  <= '0;
      baud     <= RATE_W'(BAUD_RST);
      shadow   <= RATE_W'(BAUD_RST);
      cnt      <= '0;
      err_flag <= 1'b0;
      tmo_flag <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (we_ctrl)    ctrl    <= wdata[CTRL_W-1:0];
      if (we_irq_en)  irq_en  <= wdata[IRQ_EN_W-1:0];
      if (we_scratch) scratch <= wdata;

      if (we_baud) begin
        shadow <= wdata[RATE_W-1:0];
        cnt    <= '0;
      end else if (commit_evt) begin
        baud <= shadow;
      end else if (timeout_evt) begin
        shadow <= baud;
      end else if (state == PEND) begin
        cnt <= cnt + 1'b1;
      end

      // Sticky bits: a set in the same cycle as a W1C wins
      err_flag <= error | (err_flag & ~(we_status & wdata[STAT_ERROR]));
      tmo_flag <= timeout_evt | (tmo_flag & ~(we_status & wdata[STAT_TIMEOUT]));

      irq <= |({tmo_flag, err_flag} & irq_en[STAT_TIMEOUT:STAT_ERROR]);
    end
  end

endmodule

// File: rtl/uart_cfg_bank.sv
// Multi-channel UART configuration register bank.
// Address = {channel index, 3-bit offset}. Each channel is a uart_cfg_channel;
// this level decodes writes, muxes the two read ports and applies the read
// latency (0: combinational with write bypass, 1: registered).
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   wr_en, wr_addr, wr_data         write port
//   rd_addr_a/b, rd_data_a/b,
//   rd_valid_a/b                    two independent read ports
//   uart_busy, uart_error, update_ok  per-channel hardware status
//   uart_enable, uart_mode, uart_rate, commit_req, irq  per-channel controls
module uart_cfg_bank
  import uart_cfg_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int N_CH         = 2,
  parameter int READ_LATENCY = 1,
  parameter int BAUD_RST     = 9600,
  parameter int COMMIT_TMO   = 15,
  localparam int AW          = $clog2(N_CH) + 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic [AW-1:0]          rd_addr_a,
  input  logic [AW-1:0]          rd_addr_b,
  output logic [DATA_WIDTH-1:0]  rd_data_a,
  output logic [DATA_WIDTH-1:0]  rd_data_b,
  output logic                   rd_valid_a,
  output logic                   rd_valid_b,
  input  logic [N_CH-1:0]        uart_busy,
  input  logic [N_CH-1:0]        uart_error,
  input  logic [N_CH-1:0]        update_ok,
  output logic [N_CH-1:0]        uart_enable,
  output logic [3*N_CH-1:0]      uart_mode,
  output logic [16*N_CH-1:0]     uart_rate,
  output logic [N_CH-1:0]        commit_req,
  output logic [N_CH-1:0]        irq
);

  // Channel index as a plain number; with N_CH=1 there are no index bits
  // and every address maps to channel 0.
  function automatic logic [31:0] chan_of(input logic [AW-1:0] a);
    return 32'(a) >> 3;
  endfunction

  logic [CTRL_W-1:0]     ctrl_w    [N_CH];
  logic [RATE_W-1:0]     baud_w    [N_CH];
  logic [IRQ_EN_W-1:0]   irq_en_w  [N_CH];
  logic [DATA_WIDTH-1:0] scratch_w [N_CH];
  logic [STATUS_W-1:0]   status_w  [N_CH];
  logic                  err_w     [N_CH];
  logic                  tmo_w     [N_CH];
  commit_state_e         state_w   [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic wsel;
    assign wsel = wr_en && (chan_of(wr_addr) == 32'(i));

    uart_cfg_channel #(
      .DATA_WIDTH(DATA_WIDTH),
      .BAUD_RST  (BAUD_RST),
      .COMMIT_TMO(COMMIT_TMO)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .we_ctrl   (wsel && (wr_addr[2:0] == OFF_CTRL)),
      .we_baud   (wsel && (wr_addr[2:0] == OFF_BAUD)),
      .we_status (wsel && (wr_addr[2:0] == OFF_STATUS)),
      .we_irq_en (wsel && (wr_addr[2:0] == OFF_IRQ_EN)),
      .we_scratch(wsel && (wr_addr[2:0] == OFF_SCRATCH)),
      .wdata     (wr_data),
      .error     (uart_error[i]),
      .update_ok (update_ok[i]),
      .ctrl      (ctrl_w[i]),
      .baud      (baud_w[i]),
      .err_flag  (err_w[i]),
      .tmo_flag  (tmo_w[i]),
      .irq_en    (irq_en_w[i]),
      .scratch   (scratch_w[i]),
      .commit_req(commit_req[i]),
      .irq       (irq[i]),
      .state     (state_w[i])
    );

    // {pending, timeout, error, busy}
    assign status_w[i] = {state_w[i] == PEND, tmo_w[i], err_w[i], uart_busy[i]};

    assign uart_enable[i]               = ctrl_w[i][CTRL_EN];
    assign uart_mode[3*i +: 3]          = ctrl_w[i][CTRL_MODE_LSB +: CTRL_MODE_W];
    assign uart_rate[RATE_W*i +: RATE_W] = baud_w[i];
  end

  // Read ports: p=0 is port a, p=1 is port b
  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [AW-1:0]         addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;

    assign addr = (p == 0) ? rd_addr_a : rd_addr_b;

    always_comb begin
      data  = '0;
      valid = 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        if (chan_of(addr) == 32'(c)) begin
          case (addr[2:0])
            OFF_CTRL:    begin valid = 1'b1; data = DATA_WIDTH'(ctrl_w[c]);   end
            OFF_BAUD:    begin valid = 1'b1; data = DATA_WIDTH'(baud_w[c]);   end
            OFF_STATUS:  begin valid = 1'b1; data = DATA_WIDTH'(status_w[c]); end
            OFF_IRQ_EN:  begin valid = 1'b1; data = DATA_WIDTH'(irq_en_w[c]); end
            OFF_SCRATCH: begin valid = 1'b1; data = scratch_w[c];            end
            default:     ;
          endcase
        end
      end
    end

    if (READ_LATENCY == 0) begin : g_lat0
      // Plain RW registers forward the write data; BAUD reads the active
      // value, which a write never changes directly, and STATUS is W1C.
      always_comb begin
        out_data  = data;
        out_valid = valid;
        if (wr_en && valid && (wr_addr == addr)) begin
          case (addr[2:0])
            OFF_CTRL:    out_data = DATA_WIDTH'(wr_data[CTRL_W-1:0]);
            OFF_IRQ_EN:  out_data = DATA_WIDTH'(wr_data[IRQ_EN_W-1:0]);
            OFF_SCRATCH: out_data = wr_data;
            default:     ;
          endcase
        end
      end
    end else begin : g_lat1
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          out_data  <= '0;
          out_valid <= 1'b0;
        end else begin
          out_data  <= data;
          out_valid <= valid;
        end
      end
    end
  end

  assign rd_data_a  = g_rd[0].out_data;
  assign rd_valid_a = g_rd[0].out_valid;
  assign rd_data_b  = g_rd[1].out_data;
  assign rd_valid_b = g_rd[1].out_valid;

endmodule

// File: tb/tb_uart_cfg_bank.sv
// Bench for uart_cfg_bank: a registered-read instance (d1) and a
// combinational-read instance (d0) share all inputs. Port-a reads of d1 go
// through an expected queue checked by a separate monitor; control outputs
// and the combinational port are checked directly.
module tb_uart_cfg_bank;

  localparam int DW  = 16;
  localparam int NCH = 2;
  localparam int AW  = 4;
  localparam int W   = DW + 1;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // shared inputs
  logic           wr_en      = 1'b0;
  logic [AW-1:0]  wr_addr    = '0;
  logic [DW-1:0]  wr_data    = '0;
  logic [AW-1:0]  rd_addr_a  = '0;
  logic [AW-1:0]  rd_addr_b  = '0;
  logic [NCH-1:0] uart_busy  = '0;
  logic [NCH-1:0] uart_error = '0;
  logic [NCH-1:0] update_ok  = '0;

  // d1 outputs (READ_LATENCY=1)
  logic [DW-1:0]     d1_rd_data_a, d1_rd_data_b;
  logic              d1_rd_valid_a, d1_rd_valid_b;
  logic [NCH-1:0]    d1_uart_enable, d1_commit_req, d1_irq;
  logic [3*NCH-1:0]  d1_uart_mode;
  logic [16*NCH-1:0] d1_uart_rate;

  // d0 outputs (READ_LATENCY=0)
  logic [DW-1:0]     d0_rd_data_a, d0_rd_data_b;
  logic              d0_rd_valid_a, d0_rd_valid_b;
  logic [NCH-1:0]    d0_uart_enable, d0_commit_req, d0_irq;
  logic [3*NCH-1:0]  d0_uart_mode;
  logic [16*NCH-1:0] d0_uart_rate;

  uart_cfg_bank #(.DATA_WIDTH(DW), .N_CH(NCH), .READ_LATENCY(1),
                  .BAUD_RST(9600), .COMMIT_TMO(15)) d1 (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(d1_rd_data_a), .rd_data_b(d1_rd_data_b),
    .rd_valid_a(d1_rd_valid_a), .rd_valid_b(d1_rd_valid_b),
    .uart_busy(uart_busy), .uart_error(uart_error), .update_ok(update_ok),
    .uart_enable(d1_uart_enable), .uart_mode(d1_uart_mode), .uart_rate(d1_uart_rate),
    .commit_req(d1_commit_req), .irq(d1_irq)
  );

  uart_cfg_bank #(.DATA_WIDTH(DW), .N_CH(NCH), .READ_LATENCY(0),
                  .BAUD_RST(9600), .COMMIT_TMO(15)) d0 (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(d0_rd_data_a), .rd_data_b(d0_rd_data_b),
    .rd_valid_a(d0_rd_valid_a), .rd_valid_b(d0_rd_valid_b),
    .uart_busy(uart_busy), .uart_error(uart_error), .update_ok(update_ok),
    .uart_enable(d0_uart_enable), .uart_mode(d0_uart_mode), .uart_rate(d0_uart_rate),
    .commit_req(d0_commit_req), .irq(d0_irq)
  );

  // counters and scoreboard
  int            checks = 0;
  int            errors = 0;
  logic [W-1:0]  exp_q[$];
  string         name_q[$];
  logic          req_a    = 1'b0;
  logic          req_seen = 1'b0;
  logic [DW-1:0] rst_exp [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int ch, input int off);
    return AW'(ch * 8 + off);
  endfunction

  // driver tasks: called at a negedge, return at the next negedge
  task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] addr, input logic v, input logic [DW-1:0] d,
                    input string n);
    rd_addr_a = addr;
    req_a     = 1'b1;
    exp_q.push_back({v, d});
    name_q.push_back(n);
    @(negedge clk);
    req_a = 1'b0;
  endtask

  // monitor: a read issued before a posedge is checked at the next negedge
  always @(posedge clk) req_seen <= req_a;

  always @(negedge clk) begin : mon
    logic [W-1:0] e;
    string        n;
    if (req_seen) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: got valid=%0b data=0x%0h with nothing expected",
                 d1_rd_valid_a, d1_rd_data_a);
      end else begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if ({d1_rd_valid_a, d1_rd_data_a} !== e) begin
          errors++;
          $display("FAIL %s: got valid=%0b data=0x%0h expected valid=%0b data=0x%0h",
                   n, d1_rd_valid_a, d1_rd_data_a, e[W-1], e[DW-1:0]);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst_exp[0] = 16'd0;
    rst_exp[1] = 16'd9600;
    rst_exp[2] = 16'd0;
    rst_exp[3] = 16'd0;
    rst_exp[4] = 16'd0;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // reset state
    check("rst_commit_req", 32'(d1_commit_req), 32'h0);
    check("rst_irq", 32'(d1_irq), 32'h0);
    check("rst_uart_rate", 32'(d1_uart_rate), 32'h2580_2580);
    check("rst_uart_enable", 32'(d1_uart_enable), 32'h0);
    for (int ch = 0; ch < NCH; ch++) begin
      for (int off = 0; off < 8; off++) begin
        if (off < 5) rd(addr_of(ch, off), 1'b1, rst_exp[off], $sformatf("rst_ch%0d_off%0d", ch, off));
        else         rd(addr_of(ch, off), 1'b0, 16'h0,        $sformatf("rst_ch%0d_off%0d", ch, off));
      end
    end

    // live busy bit, also through the combinational instance
    uart_busy = 2'b01;
    rd_addr_a = addr_of(0, 2);
    #1;
    check("lat0_status_busy", 32'({d0_rd_valid_a, d0_rd_data_a}), 32'h1_0001);
    rd(addr_of(0, 2), 1'b1, 16'h1, "status_busy");
    uart_busy = 2'b00;

    // ignored writes, field masking, scratch
    wr(addr_of(1, 5), 16'hFFFF);
    rd(addr_of(1, 5), 1'b0, 16'h0, "unimpl_wr_ignored");
    wr(addr_of(1, 2), 16'h0009);
    rd(addr_of(1, 2), 1'b1, 16'h0, "status_ro_ignored");
    wr(addr_of(1, 4), 16'hA5A5);
    rd(addr_of(1, 4), 1'b1, 16'hA5A5, "scratch_rw");
    wr(addr_of(1, 3), 16'hFFFF);
    rd(addr_of(1, 3), 1'b1, 16'h0007, "irq_en_mask");
    wr(addr_of(1, 0), 16'hFFFF);
    rd(addr_of(1, 0), 1'b1, 16'h000F, "ctrl_mask");
    check("ctrl_enable_ch1", 32'(d1_uart_enable[1]), 32'h1);
    check("ctrl_mode_ch1", 32'(d1_uart_mode[5:3]), 32'h7);

    // BAUD commit on ch1
    wr(addr_of(1, 1), 16'd4800);
    check("commit_req_ch1_set", 32'(d1_commit_req), 32'h2);
    rd(addr_of(1, 1), 1'b1, 16'd9600, "baud_pend_reads_active");
    check("rate_ch1_before_ok", 32'(d1_uart_rate[31:16]), 32'd9600);
    update_ok = 2'b10;
    @(negedge clk);
    update_ok = 2'b00;
    check("rate_ch1_committed", 32'(d1_uart_rate[31:16]), 32'd4800);
    check("commit_req_ch1_clear", 32'(d1_commit_req), 32'h0);
    rd(addr_of(1, 1), 1'b1, 16'd4800, "baud_ch1_committed");
    rd(addr_of(1, 2), 1'b1, 16'h0, "status_ch1_after_commit");

    // timeout on ch0: still pending after 15 counted cycles, gone on the 16th
    wr(addr_of(0, 1), 16'd1200);
    repeat (15) @(negedge clk);
    check("pend_last_tmo_cycle", 32'(d1_commit_req[0]), 32'h1);
    @(negedge clk);
    check("pend_after_tmo", 32'(d1_commit_req[0]), 32'h0);
    rd(addr_of(0, 2), 1'b1, 16'h4, "status_timeout");
    rd(addr_of(0, 1), 1'b1, 16'd9600, "baud_after_timeout");
    check("rate_ch0_after_timeout", 32'(d1_uart_rate[15:0]), 32'd9600);
    check("irq_masked_timeout", 32'(d1_irq), 32'h0);
    wr(addr_of(0, 2), 16'h0004);
    rd(addr_of(0, 2), 1'b1, 16'h0, "status_timeout_w1c");

    // error interrupt on ch0
    wr(addr_of(0, 3), 16'h0002);
    uart_error = 2'b01;
    @(negedge clk);
    uart_error = 2'b00;
    @(negedge clk);
    check("irq_error", 32'(d1_irq), 32'h1);
    uart_error = 2'b01;
    wr(addr_of(0, 2), 16'h0002);
    uart_error = 2'b00;
    rd(addr_of(0, 2), 1'b1, 16'h2, "w1c_set_wins");
    check("irq_held", 32'(d1_irq), 32'h1);
    wr(addr_of(0, 2), 16'h0002);
    rd(addr_of(0, 2), 1'b1, 16'h0, "status_error_w1c");
    check("irq_cleared", 32'(d1_irq), 32'h0);

    // read latency and bypass, port b
    wr_en = 1'b1; wr_addr = addr_of(0, 0); wr_data = 16'h000B; rd_addr_b = addr_of(0, 0);
    #1;
    check("lat0_bypass_ctrl", 32'({d0_rd_valid_b, d0_rd_data_b}), 32'h1_000B);
    @(negedge clk);
    wr_en = 1'b0;
    check("lat1_old_ctrl", 32'({d1_rd_valid_b, d1_rd_data_b}), 32'h1_0000);
    check("ctrl_enable_ch0", 32'(d1_uart_enable[0]), 32'h1);
    check("ctrl_mode_ch0", 32'(d1_uart_mode[2:0]), 32'h5);

    wr_en = 1'b1; wr_data = 16'hFFF5;
    #1;
    check("lat0_bypass_ctrl_mask", 32'({d0_rd_valid_b, d0_rd_data_b}), 32'h1_0005);
    @(negedge clk);
    wr_en = 1'b0;
    check("lat1_old_ctrl_b", 32'({d1_rd_valid_b, d1_rd_data_b}), 32'h1_000B);

    wr_en = 1'b1; wr_addr = addr_of(1, 3); wr_data = 16'h0002; rd_addr_b = addr_of(1, 3);
    #1;
    check("lat0_bypass_irq_en", 32'({d0_rd_valid_b, d0_rd_data_b}), 32'h1_0002);
    @(negedge clk);
    wr_en = 1'b0;
    check("lat1_old_irq_en", 32'({d1_rd_valid_b, d1_rd_data_b}), 32'h1_0007);

    wr_en = 1'b1; wr_addr = addr_of(0, 1); wr_data = 16'd300; rd_addr_b = addr_of(0, 1);
    #1;
    check("lat0_no_baud_bypass", 32'({d0_rd_valid_b, d0_rd_data_b}), 32'h1_2580);
    @(negedge clk);
    wr_en = 1'b0;
    rd_addr_b = addr_of(0, 6);
    #1;
    check("lat0_unimpl", 32'({d0_rd_valid_b, d0_rd_data_b}), 32'h0);
    @(negedge clk);

    // BAUD write beats a coincident update_ok and restarts the counter
    wr(addr_of(0, 1), 16'd2400);
    repeat (10) @(negedge clk);
    update_ok = 2'b01;
    wr(addr_of(0, 1), 16'd600);
    update_ok = 2'b00;
    check("no_commit_on_collision", 32'(d1_uart_rate[15:0]), 32'd9600);
    check("pend_after_collision", 32'(d1_commit_req[0]), 32'h1);
    repeat (15) @(negedge clk);
    check("counter_restarted", 32'(d1_commit_req[0]), 32'h1);
    update_ok = 2'b01;
    @(negedge clk);
    update_ok = 2'b00;
    check("commit_on_last_cycle", 32'(d1_uart_rate[15:0]), 32'd600);
    check("commit_req_ch0_clear", 32'(d1_commit_req), 32'h0);
    rd(addr_of(0, 2), 1'b1, 16'h0, "no_tmo_when_ok_last");

    // reset while ch1 is pending
    wr(addr_of(1, 1), 16'd1200);
    repeat (3) @(negedge clk);
    check("pend_before_reset", 32'(d1_commit_req[1]), 32'h1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_commit_req", 32'(d1_commit_req), 32'h0);
    check("rst_mid_rate", 32'(d1_uart_rate), 32'h2580_2580);
    check("rst_mid_irq", 32'(d1_irq), 32'h0);
    check("rst_mid_rd_regs", 32'({d1_rd_valid_a, d1_rd_data_a}), 32'h0);
    repeat (20) @(negedge clk);
    rd(addr_of(1, 2), 1'b1, 16'h0, "rst_no_timeout");
    rd(addr_of(1, 1), 1'b1, 16'd9600, "rst_baud_ch1");
    rd(addr_of(0, 0), 1'b1, 16'h0, "rst_ctrl_ch0");
    check("d0_rate", 32'(d0_uart_rate), 32'h2580_2580);
    check("d0_ctl", 32'({d0_commit_req, d0_irq, d0_uart_enable, d0_uart_mode}), 32'h0);

    @(negedge clk);
    check("scoreboard_drain", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
